mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Multi-cycle control unit for the MIPS multi-cycle CPU core. A Moore state machine that sequences the shared ALU, register file, PC and data-memory port over 3–5 cycles per instruction. It holds in memory-access states until `MIO_ready` is high. It drives every mux select and write enable of the multi-cycle datapath, and sits inside the `mips` core beside the datapath.

## Interface
Parameters: none; all encodings are fixed in `mcpu_pkg`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to IF.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, combinational from the datapath.
- `MIO_ready`  in  1  memory/IO ready for the current data access.
- `PC_wr`  out  1  PC write enable, with branch condition already resolved.
- `IR_wr`  out  1  instruction register write.
- `RegWrite`  out  1  register file write.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `MemtoReg`  out  2  00 ALUOut, 01 MDR, 10 {imm,16'h0}, 11 PC.
- `ALUSrcA`  out  1  0 PC, 1 A.
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 ext(imm), 11 sext(imm)<<2.
- `ext_zero`  out  1  1 selects zero-extend of imm (andi/ori/xori).
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b0}, 11 A.
- `ALU_Control`  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor.
- `mem_w`  out  1  data memory write.
- `CPU_MIO`  out  1  data memory/IO access in progress.
- `illegal`  out  1  high in ID when opcode/funct is unsupported.
- `state_out`  out  4  current state, for debug display.

## Operation
States, with the outputs that are active in each (all others are 0 or 00):
- **IF(0)**: ALUSrcA=0, ALUSrcB=01, add, PCSource=00, IR_wr=1, PC_wr=1 → ID.
- **ID(1)**: ALUSrcA=0, ALUSrcB=11, add (branch target → ALUOut). Dispatch by opcode:
  - lw/sw → MA
  - R-type → RX, or JR if funct=001000
  - beq/bne → BR
  - j/jal → JP
  - addi/andi/ori/xori/slti → IX
  - lui → LU
  - otherwise → IF with `illegal`=1
- **MA(2)**: ALUSrcA=1, ALUSrcB=10, add → MR (lw) or MW (sw).
- **MR(3)**: CPU_MIO=1. Hold while MIO_ready=0; when it is 1 → LW.
- **LW(4)**: RegWrite, RegDst=00, MemtoReg=01 → IF.
- **MW(5)**: CPU_MIO=1, mem_w=1. Hold while MIO_ready=0; when it is 1 → IF. mem_w stays asserted throughout the stall.
- **RX(6)**: ALUSrcA=1, ALUSrcB=00, ALU_Control from funct → RW.
  - add/addu→010, sub/subu→110, and→000, or→001, xor→011, nor→100, slt→111.
- **RW(7)**: RegWrite, RegDst=01, MemtoReg=00 → IF.
- **BR(8)**: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PC_wr = zero (beq) or !zero (bne) → IF.
- **JP(9)**: PCSource=10, PC_wr=1. For jal also RegWrite, RegDst=10, MemtoReg=11 (PC already holds PC+4) → IF.
- **IX(10)**: ALUSrcA=1, ALUSrcB=10, ext_zero for andi/ori/xori. ALU: addi 010, andi 000, ori 001, xori 011, slti 111 → IW.
- **IW(11)**: RegWrite, RegDst=00, MemtoReg=00 → IF.
- **LU(12)**: RegWrite, RegDst=00, MemtoReg=10 → IF.
- **JR(13)**: PCSource=11, PC_wr=1 → IF.
- Unused encodings 14–15 → IF.

## Timing
- Outputs are Moore (decoded from state). The only exceptions are PC_wr in BR, which is combinational on `zero`, and `illegal` in ID, which is combinational on opcode/funct.
- Cycles per instruction:
  - beq/bne/j/jal/jr/lui: 3
  - R-type/addi-class/sw: 4
  - lw: 5
  - each cycle MIO_ready=0 in MR/MW adds one cycle.
- Reset is asynchronous:
  - state → IF immediately.
  - While `reset`=1, every write enable (PC_wr, IR_wr, RegWrite, mem_w) and CPU_MIO is forced to 0. The selects show their IF values and `state_out`=0.
  - Reset asserted mid-instruction (including a stalled MW) abandons that instruction with no further writes.
- On the first rising edge after reset deasserts, the IF writes take effect.
- MIO_ready is sampled only in MR/MW and ignored elsewhere.

## Structure
- `mcpu_pkg` holds:
  - state enum
  - opcode/funct constants
  - ALU_Control codes
  - RegDst/MemtoReg/ALUSrcB/PCSource select constants
- Sub-module `mcpu_alu_dec`: combinational funct → ALU_Control for R-type, plus the legal-funct flag.
- Top level: one state register and one combinational next-state/output block.

## Test plan
- Reset high mid-MW with MIO_ready=0 → state_out=0 and mem_w=0 immediately. After release, IR_wr=PC_wr=1 on the first cycle.
- add (op 000000, funct 100000) → states 0,1,6,7. ALU_Control=010 in RX; RegWrite=1, RegDst=01 in RW.
- lw with MIO_ready low for 2 cycles in MR → states 0,1,2,3,3,3,4 (7 cycles). MemtoReg=01 in LW.
- beq with zero=1 → PC_wr=1 and PCSource=01 in BR. bne with zero=1 → PC_wr=0. Both take 3 cycles.
- jal → JP asserts PC_wr, RegWrite, RegDst=10, MemtoReg=11. ori → ext_zero=1, ALU_Control=001.
- Opcode 111111 → illegal=1 in ID, then IF with no RegWrite/mem_w asserted.

Source files
------------

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - state, opcode/funct, ALU and select encodings for the multi-cycle control unit
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF = 4'd0,
    S_ID = 4'd1,
    S_MA = 4'd2,
    S_MR = 4'd3,
    S_LW = 4'd4,
    S_MW = 4'd5,
    S_RX = 4'd6,
    S_RW = 4'd7,
    S_BR = 4'd8,
    S_JP = 4'd9,
    S_IX = 4'd10,
    S_IW = 4'd11,
    S_LU = 4'd12,
    S_JR = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_RA  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_LUI = 2'b10;
  localparam logic [1:0] M2R_PC  = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  // ALU operation for the immediate-class instructions handled in IX
  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_XORI: imm_alu = ALU_XOR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// rtl/mcpu_ctrl_if.sv - control unit <-> datapath signal bundle
interface mcpu_ctrl_if;
  import mcpu_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       MIO_ready;
  logic       PC_wr;
  logic       IR_wr;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ext_zero;
  logic [1:0] PCSource;
  logic [2:0] ALU_Control;
  logic       mem_w;
  logic       CPU_MIO;
  logic       illegal;
  logic [3:0] state_out;

  // Controller side
  modport master (
    input  opcode, funct, zero, MIO_ready,
    output PC_wr, IR_wr, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
           ext_zero, PCSource, ALU_Control, mem_w, CPU_MIO, illegal, state_out
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero, MIO_ready,
    input  PC_wr, IR_wr, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
           ext_zero, PCSource, ALU_Control, mem_w, CPU_MIO, illegal, state_out
  );

endinterface

// File: rtl/mcpu_alu_dec.sv
// rtl/mcpu_alu_dec.sv - R-type funct to ALU_Control decode with legal-funct flag
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  // jr is legal but never reaches RX, so its ALU code is irrelevant
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
      FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
      FN_AND:          alu_ctrl = ALU_AND;
      FN_OR:           alu_ctrl = ALU_OR;
      FN_XOR:          alu_ctrl = ALU_XOR;
      FN_NOR:          alu_ctrl = ALU_NOR;
      FN_SLT:          alu_ctrl = ALU_SLT;
      FN_JR:           alu_ctrl = ALU_ADD;
      default:         legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS control FSM driving the datapath selects and write enables
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mcpu_ctrl_if.master   bus
);

  state_t     state;
  state_t     next;
  logic [2:0] r_alu;
  logic       r_legal;

  logic       pc_wr, ir_wr, reg_write, mem_w, cpu_mio, illegal;
  logic       alu_src_a, ext_zero;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0] alu_control;

  mcpu_alu_dec u_alu_dec (
    .funct    (bus.funct),
    .alu_ctrl (r_alu),
    .legal    (r_legal)
  );

  // State register; reset drops straight back to instruction fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= next;
  end

  // Next-state dispatch and per-state datapath control
  always_comb begin
    next        = S_IF;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    reg_write   = 1'b0;
    mem_w       = 1'b0;
    cpu_mio     = 1'b0;
    illegal     = 1'b0;
    alu_src_a   = 1'b0;
    ext_zero    = 1'b0;
    reg_dst     = DST_RT;
    mem_to_reg  = M2R_ALU;
    alu_src_b   = SRCB_B;
    pc_source   = PCS_ALU;
    alu_control = ALU_AND;
    case (state)
      S_IF: begin
        alu_src_b   = SRCB_4;
        alu_control = ALU_ADD;
        ir_wr       = 1'b1;
        pc_wr       = 1'b1;
        next        = S_ID;
      end
      S_ID: begin
        // Branch target is computed here speculatively into ALUOut
        alu_src_b   = SRCB_BOFF;
        alu_control = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW:   next = S_MA;
          OP_RTYPE: begin
            if (!r_legal)                  illegal = 1'b1;
            else if (bus.funct == FN_JR)   next = S_JR;
            else                           next = S_RX;
          end
          OP_BEQ, OP_BNE: next = S_BR;
          OP_J, OP_JAL:   next = S_JP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: next = S_IX;
          OP_LUI:         next = S_LU;
          default:        illegal = 1'b1;
        endcase
      end
      S_MA: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_EXT;
        alu_control = ALU_ADD;
        next        = (bus.opcode == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        cpu_mio = 1'b1;
        next    = bus.MIO_ready ? S_LW : S_MR;
      end
      S_LW: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_MDR;
      end
      S_MW: begin
        cpu_mio = 1'b1;
        mem_w   = 1'b1;
        next    = bus.MIO_ready ? S_IF : S_MW;
      end
      S_RX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_B;
        alu_control = r_alu;
        next        = S_RW;
      end
      S_RW: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RD;
        mem_to_reg = M2R_ALU;
      end
      S_BR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_B;
        alu_control = ALU_SUB;
        pc_source   = PCS_ALUOUT;
        pc_wr       = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      S_JP: begin
        pc_source = PCS_JUMP;
        pc_wr     = 1'b1;
        if (bus.opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_IX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_EXT;
        ext_zero    = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI) ||
                      (bus.opcode == OP_XORI);
        alu_control = imm_alu(bus.opcode);
        next        = S_IW;
      end
      S_IW: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
      end
      S_LU: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_LUI;
      end
      S_JR: begin
        pc_source = PCS_REG;
        pc_wr     = 1'b1;
      end
      default: next = S_IF;
    endcase
  end

  // Write enables and the memory strobe are suppressed while reset is held
  assign bus.PC_wr       = pc_wr     & ~reset;
  assign bus.IR_wr       = ir_wr     & ~reset;
  assign bus.RegWrite    = reg_write & ~reset;
  assign bus.mem_w       = mem_w     & ~reset;
  assign bus.CPU_MIO     = cpu_mio   & ~reset;
  assign bus.illegal     = illegal;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ext_zero    = ext_zero;
  assign bus.PCSource    = pc_source;
  assign bus.ALU_Control = alu_control;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - directed self-checking bench for mcpu_ctrl
module tb_mcpu_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mcpu_ctrl_if bus();

  mcpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'b100000; bus.zero = 1'b0; bus.MIO_ready = 1'b1;
    #2;
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.state_out); end
    checks++; if (bus.PC_wr !== 1'b0 || bus.IR_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got pc=%b ir=%b exp 0 0", bus.PC_wr, bus.IR_wr); end
    checks++; if (bus.ALUSrcB !== 2'b01 || bus.ALU_Control !== 3'b010) begin errors++; $display("FAIL rst_sel got srcb=%b alu=%b exp 01 010", bus.ALUSrcB, bus.ALU_Control); end
    tick(); tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL rst_hold got=%0d exp=0", bus.state_out); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.PC_wr !== 1'b1 || bus.IR_wr !== 1'b1) begin errors++; $display("FAIL rst_release got pc=%b ir=%b exp 1 1", bus.PC_wr, bus.IR_wr); end
  endtask

  task automatic test_add();
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    tick();
    checks++; if (bus.state_out !== 4'd1 || bus.ALUSrcB !== 2'b11) begin errors++; $display("FAIL add_id got st=%0d srcb=%b exp 1 11", bus.state_out, bus.ALUSrcB); end
    tick();
    checks++; if (bus.state_out !== 4'd6 || bus.ALU_Control !== 3'b010 || bus.ALUSrcA !== 1'b1) begin errors++; $display("FAIL add_rx got st=%0d alu=%b a=%b exp 6 010 1", bus.state_out, bus.ALU_Control, bus.ALUSrcA); end
    tick();
    checks++; if (bus.state_out !== 4'd7 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b01) begin errors++; $display("FAIL add_rw got st=%0d rw=%b dst=%b exp 7 1 01", bus.state_out, bus.RegWrite, bus.RegDst); end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL add_end got st=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fn [5];
    logic [2:0] ex [5];
    fn = '{6'b100010, 6'b100101, 6'b100111, 6'b101010, 6'b100110};
    ex = '{3'b110, 3'b001, 3'b100, 3'b111, 3'b011};
    for (int i = 0; i < 5; i++) begin
      bus.opcode = 6'b000000; bus.funct = fn[i];
      tick(); tick();
      checks++; if (bus.state_out !== 4'd6 || bus.ALU_Control !== ex[i]) begin errors++; $display("FAIL rx_alu[%0d] got st=%0d alu=%b exp 6 %b", i, bus.state_out, bus.ALU_Control, ex[i]); end
      tick(); tick();
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_st [7];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    bus.opcode = 6'b100011; bus.MIO_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bus.MIO_ready = 1'b1;
      #1;
      checks++; if (bus.state_out !== exp_st[i]) begin errors++; $display("FAIL lw_seq[%0d] got st=%0d exp %0d", i, bus.state_out, exp_st[i]); end
      if (i == 3) begin
        checks++; if (bus.CPU_MIO !== 1'b1 || bus.mem_w !== 1'b0) begin errors++; $display("FAIL lw_mr got mio=%b memw=%b exp 1 0", bus.CPU_MIO, bus.mem_w); end
      end
      if (i == 6) begin
        checks++; if (bus.MemtoReg !== 2'b01 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b00) begin errors++; $display("FAIL lw_wb got m2r=%b rw=%b dst=%b exp 01 1 00", bus.MemtoReg, bus.RegWrite, bus.RegDst); end
      end
      if (i < 6) tick();
    end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL lw_end got st=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_branch();
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd8 || bus.PC_wr !== 1'b1 || bus.PCSource !== 2'b01 || bus.ALU_Control !== 3'b110) begin errors++; $display("FAIL beq_br got st=%0d pcwr=%b pcs=%b alu=%b exp 8 1 01 110", bus.state_out, bus.PC_wr, bus.PCSource, bus.ALU_Control); end
    bus.zero = 1'b0; #1;
    checks++; if (bus.PC_wr !== 1'b0) begin errors++; $display("FAIL beq_nz got pcwr=%b exp 0", bus.PC_wr); end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL beq_end got st=%0d exp 0", bus.state_out); end
    bus.opcode = 6'b000101; bus.zero = 1'b1;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd8 || bus.PC_wr !== 1'b0) begin errors++; $display("FAIL bne_z got st=%0d pcwr=%b exp 8 0", bus.state_out, bus.PC_wr); end
    bus.zero = 1'b0; #1;
    checks++; if (bus.PC_wr !== 1'b1) begin errors++; $display("FAIL bne_nz got pcwr=%b exp 1", bus.PC_wr); end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL bne_end got st=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_jump_imm();
    bus.opcode = 6'b000011;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd9 || bus.PC_wr !== 1'b1 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b10 || bus.MemtoReg !== 2'b11 || bus.PCSource !== 2'b10) begin errors++; $display("FAIL jal_jp got st=%0d pcwr=%b rw=%b dst=%b m2r=%b pcs=%b exp 9 1 1 10 11 10", bus.state_out, bus.PC_wr, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.PCSource); end
    tick();
    bus.opcode = 6'b000010;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd9 || bus.PC_wr !== 1'b1 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL j_jp got st=%0d pcwr=%b rw=%b exp 9 1 0", bus.state_out, bus.PC_wr, bus.RegWrite); end
    tick();
    bus.opcode = 6'b001101;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd10 || bus.ext_zero !== 1'b1 || bus.ALU_Control !== 3'b001 || bus.ALUSrcB !== 2'b10) begin errors++; $display("FAIL ori_ix got st=%0d ez=%b alu=%b srcb=%b exp 10 1 001 10", bus.state_out, bus.ext_zero, bus.ALU_Control, bus.ALUSrcB); end
    tick();
    checks++; if (bus.state_out !== 4'd11 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b00) begin errors++; $display("FAIL ori_iw got st=%0d rw=%b dst=%b exp 11 1 00", bus.state_out, bus.RegWrite, bus.RegDst); end
    tick();
    bus.opcode = 6'b001000;
    tick(); tick();
    checks++; if (bus.ext_zero !== 1'b0 || bus.ALU_Control !== 3'b010) begin errors++; $display("FAIL addi_ix got ez=%b alu=%b exp 0 010", bus.ext_zero, bus.ALU_Control); end
    tick(); tick();
    bus.opcode = 6'b001111;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd12 || bus.MemtoReg !== 2'b10 || bus.RegWrite !== 1'b1) begin errors++; $display("FAIL lui_lu got st=%0d m2r=%b rw=%b exp 12 10 1", bus.state_out, bus.MemtoReg, bus.RegWrite); end
    tick();
    bus.opcode = 6'b000000; bus.funct = 6'b001000;
    tick(); tick();
    checks++; if (bus.state_out !== 4'd13 || bus.PC_wr !== 1'b1 || bus.PCSource !== 2'b11) begin errors++; $display("FAIL jr_jr got st=%0d pcwr=%b pcs=%b exp 13 1 11", bus.state_out, bus.PC_wr, bus.PCSource); end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL jr_end got st=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b111111;
    tick();
    checks++; if (bus.state_out !== 4'd1 || bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_op got st=%0d ill=%b exp 1 1", bus.state_out, bus.illegal); end
    tick();
    checks++; if (bus.state_out !== 4'd0 || bus.RegWrite !== 1'b0 || bus.mem_w !== 1'b0) begin errors++; $display("FAIL ill_next got st=%0d rw=%b memw=%b exp 0 0 0", bus.state_out, bus.RegWrite, bus.mem_w); end
    bus.opcode = 6'b000000; bus.funct = 6'b111111;
    tick();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_fn got ill=%b exp 1", bus.illegal); end
    bus.funct = 6'b100000; #1;
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL legal_fn got ill=%b exp 0", bus.illegal); end
    bus.funct = 6'b111111;
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL ill_fn_next got st=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_sw_reset();
    bus.opcode = 6'b101011; bus.MIO_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.state_out !== 4'd5 || bus.mem_w !== 1'b1 || bus.CPU_MIO !== 1'b1) begin errors++; $display("FAIL sw_mw got st=%0d memw=%b mio=%b exp 5 1 1", bus.state_out, bus.mem_w, bus.CPU_MIO); end
    tick();
    checks++; if (bus.state_out !== 4'd0) begin errors++; $display("FAIL sw_end got st=%0d exp 0", bus.state_out); end
    bus.MIO_ready = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (bus.state_out !== 4'd5 || bus.mem_w !== 1'b1) begin errors++; $display("FAIL sw_stall got st=%0d memw=%b exp 5 1", bus.state_out, bus.mem_w); end
    #2; reset = 1'b1; #1;
    checks++; if (bus.state_out !== 4'd0 || bus.mem_w !== 1'b0 || bus.CPU_MIO !== 1'b0) begin errors++; $display("FAIL sw_rst got st=%0d memw=%b mio=%b exp 0 0 0", bus.state_out, bus.mem_w, bus.CPU_MIO); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.IR_wr !== 1'b1 || bus.PC_wr !== 1'b1 || bus.state_out !== 4'd0) begin errors++; $display("FAIL sw_release got ir=%b pc=%b st=%0d exp 1 1 0", bus.IR_wr, bus.PC_wr, bus.state_out); end
    bus.MIO_ready = 1'b1;
    tick();
    checks++; if (bus.state_out !== 4'd1) begin errors++; $display("FAIL sw_restart got st=%0d exp 1", bus.state_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype_alu();
    test_lw_stall();
    test_branch();
    test_jump_imm();
    test_illegal();
    test_sw_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
